// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 32 x 20-bit data memory, load/store handling and
// the MEM/WB output register. Loads take two cycles (stall, then write-back);
// every other instruction passes through in one cycle.
module mem_wb_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] instruction,
  input  logic [19:0] aluRESULT,
  input  logic [19:0] dataRFOut2,
  output logic        stall,
  output logic        wbEnable,
  output logic [3:0]  wbDest,
  output logic [19:0] wbData,
  output logic [19:0] instructionWB
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int MEM_WORDS = 32;

  state_t state_reg, state_next;

  // MEM/WB register and its next-state values
  logic        wb_enable_reg, wb_enable_next;
  logic [3:0]  wb_dest_reg,   wb_dest_next;
  logic [19:0] wb_data_reg,   wb_data_next;
  logic [19:0] instr_wb_reg,  instr_wb_next;

  // Pending-load holding registers, captured on the stall edge
  logic [19:0] rdata_reg;
  logic [3:0]  load_dest_reg;
  logic [19:0] load_instr_reg;
  logic        load_latch;

  // Data memory; cleared by reset, so it is kept in flops
  logic [19:0] mem_reg [MEM_WORDS];
  logic        mem_we;

  logic [3:0] opcode;
  logic [4:0] addr;
  logic       is_nop, is_ld, is_st, is_ctrl, is_alu;

  assign opcode  = instruction[19:16];
  assign addr    = aluRESULT[4:0];
  assign is_nop  = (opcode == 4'h0);
  assign is_ld   = (opcode == 4'h1);
  assign is_st   = (opcode == 4'h2);
  assign is_ctrl = opcode[3];
  assign is_alu  = !(is_nop || is_ld || is_st || is_ctrl);

  assign wbEnable      = wb_enable_reg;
  assign wbDest        = wb_dest_reg;
  assign wbData        = wb_data_reg;
  assign instructionWB = instr_wb_reg;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, stall and MEM/WB next values
  always_comb begin
    state_next     = state_reg;
    stall          = 1'b0;
    mem_we         = 1'b0;
    load_latch     = 1'b0;
    wb_enable_next = wb_enable_reg;
    wb_dest_next   = wb_dest_reg;
    wb_data_next   = wb_data_reg;
    instr_wb_next  = instr_wb_reg;
    case (state_reg)
      IDLE: begin
        if (is_ld) begin
          // Hold upstream for one cycle; push a bubble into WB meanwhile.
          // Reset forces IDLE, and stall must stay low while it is held.
          stall          = !reset;
          state_next     = LOAD_WAIT;
          load_latch     = 1'b1;
          wb_enable_next = 1'b0;
          wb_data_next   = 20'h0;
          instr_wb_next  = 20'h0;
        end else if (is_alu) begin
          wb_enable_next = 1'b1;
          wb_dest_next   = instruction[15:12];
          wb_data_next   = aluRESULT;
          instr_wb_next  = instruction;
        end else begin
          // NOP, ST and control: no register write
          mem_we         = is_st;
          wb_enable_next = 1'b0;
          wb_dest_next   = instruction[15:12];
          wb_data_next   = 20'h0;
          instr_wb_next  = instruction;
        end
      end
      LOAD_WAIT: begin
        // Inputs still carry the held LD and are ignored here
        state_next     = IDLE;
        wb_enable_next = 1'b1;
        wb_dest_next   = load_dest_reg;
        wb_data_next   = rdata_reg;
        instr_wb_next  = load_instr_reg;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // MEM/WB output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_enable_reg <= 1'b0;
      wb_dest_reg   <= 4'h0;
      wb_data_reg   <= 20'h0;
      instr_wb_reg  <= 20'h0;
    end else begin
      wb_enable_reg <= wb_enable_next;
      wb_dest_reg   <= wb_dest_next;
      wb_data_reg   <= wb_data_next;
      instr_wb_reg  <= instr_wb_next;
    end
  end

  // Capture the load's read data and destination on the stall edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_reg      <= 20'h0;
      load_dest_reg  <= 4'h0;
      load_instr_reg <= 20'h0;
    end else if (load_latch) begin
      rdata_reg      <= mem_reg[addr];
      load_dest_reg  <= instruction[15:12];
      load_instr_reg <= instruction;
    end
  end

  // Data memory write port; a store at edge N is visible to a load at N+1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_reg[i] <= 20'h0;
      end
    end else if (mem_we) begin
      mem_reg[addr] <= dataRFOut2;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: reset checks, a directed vector table, a reset
// during a pending load, and random traffic against a reference model.
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic [19:0] instruction;
  logic [19:0] aluRESULT;
  logic [19:0] dataRFOut2;
  logic        stall;
  logic        wbEnable;
  logic [3:0]  wbDest;
  logic [19:0] wbData;
  logic [19:0] instructionWB;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  mem_wb_stage dut (
    .clock         (clock),
    .reset         (reset),
    .instruction   (instruction),
    .aluRESULT     (aluRESULT),
    .dataRFOut2    (dataRFOut2),
    .stall         (stall),
    .wbEnable      (wbEnable),
    .wbDest        (wbDest),
    .wbData        (wbData),
    .instructionWB (instructionWB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] m_mem [32];
  bit          m_pending;
  logic [3:0]  m_pdest;
  logic [19:0] m_pdata;
  logic [19:0] m_pinstr;
  logic        e_en;
  logic [3:0]  e_dest;
  logic [19:0] e_data;
  logic [19:0] e_instr;
  bit          e_data_known;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 20'h0;
    m_pending    = 0;
    m_pdest      = 4'h0;
    m_pdata      = 20'h0;
    m_pinstr     = 20'h0;
    e_en         = 1'b0;
    e_dest       = 4'h0;
    e_data       = 20'h0;
    e_instr      = 20'h0;
    e_data_known = 1;
  endtask

  // One cycle: drive inputs, check stall, clock, check outputs vs the model
  task automatic step_model(input logic [19:0] ins, input logic [19:0] alu, input logic [19:0] d);
    logic [3:0] op;
    logic       e_stall;
    int         a;
    instruction = ins;
    aluRESULT   = alu;
    dataRFOut2  = d;
    op = ins[19:16];
    a  = int'(alu[4:0]);
    e_stall = !m_pending && (op == 4'h1);
    @(negedge clock);
    check("stall", {19'h0, stall}, {19'h0, e_stall});
    @(posedge clock);
    #1;
    if (m_pending) begin
      m_pending = 0;
      e_en = 1'b1; e_dest = m_pdest; e_data = m_pdata; e_instr = m_pinstr; e_data_known = 1;
    end else if (op == 4'h1) begin
      m_pending = 1;
      m_pdest = ins[15:12]; m_pdata = m_mem[a]; m_pinstr = ins;
      e_en = 1'b0; e_instr = 20'h0; e_data_known = 0;
    end else if (op == 4'h0 || op == 4'h2 || op >= 4'h8) begin
      if (op == 4'h2) m_mem[a] = d;
      e_en = 1'b0; e_data = 20'h0; e_instr = ins; e_data_known = 1;
    end else begin
      e_en = 1'b1; e_dest = ins[15:12]; e_data = alu; e_instr = ins; e_data_known = 1;
    end
    check("wbEnable", {19'h0, wbEnable}, {19'h0, e_en});
    check("instructionWB", instructionWB, e_instr);
    if (e_en) check("wbDest", {16'h0, wbDest}, {16'h0, e_dest});
    if (e_data_known) check("wbData", wbData, e_data);
    n_txn++;
    $display("txn %0d instr=%h alu=%h st=%b en=%b dest=%h data=%h iwb=%h",
             n_txn, ins, alu, e_stall, wbEnable, wbDest, wbData, instructionWB);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [19:0] instr;
    logic [19:0] alu;
    logic [19:0] data;
    logic        x_stall;
    logic        x_en;
    logic [3:0]  x_dest;
    logic        chk_data;
    logic [19:0] x_data;
    logic [19:0] x_iwb;
  } vec_t;

  vec_t vecs [14];

  task automatic check_zero_outputs(input string tag);
    check({tag, " wbEnable"}, {19'h0, wbEnable}, 20'h0);
    check({tag, " wbDest"}, {16'h0, wbDest}, 20'h0);
    check({tag, " wbData"}, wbData, 20'h0);
    check({tag, " instructionWB"}, instructionWB, 20'h0);
    check({tag, " stall"}, {19'h0, stall}, 20'h0);
  endtask

  initial begin
    //            instr      alu        data      st  en  dest chk data      iwb
    vecs[0]  = '{20'h00000, 20'h00000, 20'h00000, 0, 0, 4'h0, 1, 20'h00000, 20'h00000};
    vecs[1]  = '{20'h35000, 20'h00ABC, 20'h00000, 0, 1, 4'h5, 1, 20'h00ABC, 20'h35000};
    vecs[2]  = '{20'h20000, 20'h00023, 20'h12345, 0, 0, 4'h0, 1, 20'h00000, 20'h20000};
    vecs[3]  = '{20'h17000, 20'h00003, 20'h00000, 1, 0, 4'h0, 0, 20'h00000, 20'h00000};
    vecs[4]  = '{20'h17000, 20'h00003, 20'h00000, 0, 1, 4'h7, 1, 20'h12345, 20'h17000};
    vecs[5]  = '{20'h14000, 20'h00003, 20'h00000, 1, 0, 4'h0, 0, 20'h00000, 20'h00000};
    vecs[6]  = '{20'h14000, 20'h00003, 20'h00000, 0, 1, 4'h4, 1, 20'h12345, 20'h14000};
    vecs[7]  = '{20'h16000, 20'h00004, 20'h00000, 1, 0, 4'h0, 0, 20'h00000, 20'h00000};
    vecs[8]  = '{20'h16000, 20'h00004, 20'h00000, 0, 1, 4'h6, 1, 20'h00000, 20'h16000};
    vecs[9]  = '{20'hA3000, 20'h00003, 20'hFFFFF, 0, 0, 4'h0, 1, 20'h00000, 20'hA3000};
    vecs[10] = '{20'h12000, 20'hFFFE3, 20'h00000, 1, 0, 4'h0, 0, 20'h00000, 20'h00000};
    vecs[11] = '{20'h12000, 20'hFFFE3, 20'h00000, 0, 1, 4'h2, 1, 20'h12345, 20'h12000};
    vecs[12] = '{20'h40000, 20'h7FFFF, 20'h00000, 0, 1, 4'h0, 1, 20'h7FFFF, 20'h40000};
    vecs[13] = '{20'h71000, 20'h00001, 20'h00000, 0, 1, 4'h1, 1, 20'h00001, 20'h71000};

    // Reset with an LD on the inputs: stall must stay low, outputs zero
    reset       = 1'b1;
    instruction = 20'h10003;
    aluRESULT   = 20'h00003;
    dataRFOut2  = 20'h0;
    #3;
    check_zero_outputs("reset");
    @(posedge clock);
    #1;
    check_zero_outputs("reset held");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      instruction = vecs[i].instr;
      aluRESULT   = vecs[i].alu;
      dataRFOut2  = vecs[i].data;
      @(negedge clock);
      check($sformatf("vec%0d stall", i), {19'h0, stall}, {19'h0, vecs[i].x_stall});
      @(posedge clock);
      #1;
      check($sformatf("vec%0d wbEnable", i), {19'h0, wbEnable}, {19'h0, vecs[i].x_en});
      check($sformatf("vec%0d instructionWB", i), instructionWB, vecs[i].x_iwb);
      if (vecs[i].x_en)
        check($sformatf("vec%0d wbDest", i), {16'h0, wbDest}, {16'h0, vecs[i].x_dest});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d wbData", i), wbData, vecs[i].x_data);
      n_txn++;
      $display("txn %0d instr=%h alu=%h st=%b en=%b dest=%h data=%h iwb=%h",
               n_txn, vecs[i].instr, vecs[i].alu, vecs[i].x_stall,
               wbEnable, wbDest, wbData, instructionWB);
    end

    // Clean reset before model-driven phases
    instruction = 20'h0;
    reset = 1'b1;
    #2;
    check_zero_outputs("reset2");
    reset = 1'b0;
    model_reset();

    // Reset while a load is pending abandons it and clears memory
    step_model(20'h20000, 20'h00005, 20'h0AAAA);
    step_model(20'h19000, 20'h00005, 20'h0);   // now in LOAD_WAIT
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("reset in LOAD_WAIT");
    #1;
    reset = 1'b0;
    model_reset();
    step_model(20'h19000, 20'h00005, 20'h0);   // held LD processed as new LD
    step_model(20'h19000, 20'h00005, 20'h0);   // write-back of 0 (memory cleared)
    step_model(20'h00000, 20'h00000, 20'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  op;
      logic [19:0] ins, alu, d;
      op  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'h1;
      if ($urandom_range(0, 4) == 0) op = 4'h2;
      ins = {op, 16'($urandom)};
      alu = {15'($urandom), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 5) == 0) alu[4:0] = 5'($urandom);
      d   = 20'($urandom);
      step_model(ins, alu, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
